// File: rtl/ora_err_log_pkg.sv
// Shared LBIST definitions for the ORA response loggers.
//   state_t     : logger FSM encoding (IDLE, WAIT, COLLECT, DONE)
//   sat_max()   : all-ones value for a saturating counter of a given width
//   idx_width() : width needed to index n items (never less than 1)
package ora_err_log_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [31:0] sat_max(input int unsigned bits);
    if (bits >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ora_err_log_if.sv
// Bundle between the BIST controller/comparator side and the error logger.
//   master : drives start, abort, res; observes the results
//   slave  : the logger; drives busy, done, pass, err_cnt, first_err,
//            first_err_vld and the dbg_state FSM view
// Control semantics: start is a single-cycle request, honoured only when the
// logger is not busy and abort is low on the same edge. abort cancels a
// session in progress and wins over both start and a same-edge res sample.
// res is sampled once per edge while collecting; there is no back-pressure.
interface ora_err_log_if #(
  parameter int CNT_BITS = 8,
  parameter int IDX_BITS = 4
);
  import ora_err_log_pkg::*;

  logic                start;
  logic                abort;
  logic                res;
  logic                busy;
  logic                done;
  logic                pass;
  logic [CNT_BITS-1:0] err_cnt;
  logic [IDX_BITS-1:0] first_err;
  logic                first_err_vld;
  state_t              dbg_state;

  modport master (
    output start, abort, res,
    input  busy, done, pass, err_cnt, first_err, first_err_vld, dbg_state
  );

  modport slave (
    input  start, abort, res,
    output busy, done, pass, err_cnt, first_err, first_err_vld, dbg_state
  );

endinterface

// File: rtl/ora_err_log_sat_counter.sv
// Saturating up-counter, reusable across the ORA logger variants.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : synchronous clear (wins over inc)
//   inc      : add one unless already at the all-ones value
//   count    : registered count
module sat_counter
  import ora_err_log_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(sat_max(WIDTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ora_err_log.sv
// Response logger downstream of the ORA #2 comparator. Each session waits
// COMP_LAT edges for the comparator pipeline, then samples res for PAT_COUNT
// patterns, counting mismatches (saturating) and latching the first failing
// pattern index. done/pass report the verdict to the BIST controller.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ora_err_log_if slave (start/abort/res in, results out)
module ora_err_log
  import ora_err_log_pkg::*;
#(
  parameter int PAT_COUNT = 16,
  parameter int COMP_LAT  = 1,
  parameter int CNT_BITS  = 8
) (
  input logic         clk,
  input logic         rst,
  ora_err_log_if.slave bus
);

  localparam int IDX_BITS = idx_width(PAT_COUNT);
  localparam int LAT_BITS = idx_width(COMP_LAT);
  localparam logic [IDX_BITS-1:0] PAT_LAST = IDX_BITS'(PAT_COUNT - 1);
  // Only consulted in WAIT, which is unreachable when COMP_LAT is 0.
  localparam logic [LAT_BITS-1:0] LAT_LAST = LAT_BITS'((COMP_LAT > 0) ? COMP_LAT - 1 : 0);

  state_t              state;
  logic [LAT_BITS-1:0] lat_cnt;
  logic [IDX_BITS-1:0] pat_idx;
  logic [IDX_BITS-1:0] first_err;
  logic                first_vld;
  logic [CNT_BITS-1:0] err_cnt;
  logic                accept;
  logic                sample;

  // abort suppresses both a new session and the sample on its own edge.
  assign accept = ((state == IDLE) || (state == DONE)) && bus.start && !bus.abort;
  assign sample = (state == COLLECT) && !bus.abort;

  sat_counter #(.WIDTH(CNT_BITS)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (accept),
    .inc   (sample && bus.res),
    .count (err_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      pat_idx   <= '0;
      first_err <= '0;
      first_vld <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            first_err <= '0;
            first_vld <= 1'b0;
            lat_cnt   <= '0;
            pat_idx   <= '0;
            state     <= (COMP_LAT > 0) ? WAIT : COLLECT;
          end
        end
        WAIT: begin
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
            if (lat_cnt == LAT_LAST) state <= COLLECT;
          end
        end
        COLLECT: begin
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            if (bus.res && !first_vld) begin
              first_err <= pat_idx;
              first_vld <= 1'b1;
            end
            if (pat_idx == PAT_LAST) state <= DONE;
            else                     pat_idx <= pat_idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from registers only; the final err_cnt update and
  // the DONE transition land on the same edge.
  assign bus.busy          = (state == WAIT) || (state == COLLECT);
  assign bus.done          = (state == DONE);
  assign bus.pass          = (state == DONE) && (err_cnt == '0);
  assign bus.err_cnt       = err_cnt;
  assign bus.first_err     = first_err;
  assign bus.first_err_vld = first_vld;
  assign bus.dbg_state     = state;

endmodule

// File: tb/tb_ora_err_log.sv
module tb_ora_err_log;
  import ora_err_log_pkg::*;

  localparam int N = 4;
  // Per-instance configuration: A default, B CNT_BITS=2, C PAT1/LAT0, D PAT5/LAT3/CNT3
  localparam int PATS[N] = '{16, 16, 1, 5};
  localparam int LATS[N] = '{1, 1, 0, 3};
  localparam int MAXS[N] = '{255, 3, 255, 7};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, abort = 1'b0, res = 1'b0;
  always #5 clk = ~clk;

  ora_err_log_if #(.CNT_BITS(8), .IDX_BITS(4)) if_a ();
  ora_err_log_if #(.CNT_BITS(2), .IDX_BITS(4)) if_b ();
  ora_err_log_if #(.CNT_BITS(8), .IDX_BITS(1)) if_c ();
  ora_err_log_if #(.CNT_BITS(3), .IDX_BITS(3)) if_d ();

  assign if_a.start = start; assign if_a.abort = abort; assign if_a.res = res;
  assign if_b.start = start; assign if_b.abort = abort; assign if_b.res = res;
  assign if_c.start = start; assign if_c.abort = abort; assign if_c.res = res;
  assign if_d.start = start; assign if_d.abort = abort; assign if_d.res = res;

  ora_err_log #(.PAT_COUNT(16), .COMP_LAT(1), .CNT_BITS(8)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  ora_err_log #(.PAT_COUNT(16), .COMP_LAT(1), .CNT_BITS(2)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  ora_err_log #(.PAT_COUNT(1),  .COMP_LAT(0), .CNT_BITS(8)) dut_c (.clk(clk), .rst(rst), .bus(if_c));
  ora_err_log #(.PAT_COUNT(5),  .COMP_LAT(3), .CNT_BITS(3)) dut_d (.clk(clk), .rst(rst), .bus(if_d));

  logic        o_busy[N], o_done[N], o_pass[N], o_fv[N];
  logic [31:0] o_cnt[N], o_first[N];

  assign o_busy[0] = if_a.busy; assign o_done[0] = if_a.done; assign o_pass[0] = if_a.pass;
  assign o_fv[0] = if_a.first_err_vld; assign o_cnt[0] = 32'(if_a.err_cnt); assign o_first[0] = 32'(if_a.first_err);
  assign o_busy[1] = if_b.busy; assign o_done[1] = if_b.done; assign o_pass[1] = if_b.pass;
  assign o_fv[1] = if_b.first_err_vld; assign o_cnt[1] = 32'(if_b.err_cnt); assign o_first[1] = 32'(if_b.first_err);
  assign o_busy[2] = if_c.busy; assign o_done[2] = if_c.done; assign o_pass[2] = if_c.pass;
  assign o_fv[2] = if_c.first_err_vld; assign o_cnt[2] = 32'(if_c.err_cnt); assign o_first[2] = 32'(if_c.first_err);
  assign o_busy[3] = if_d.busy; assign o_done[3] = if_d.done; assign o_pass[3] = if_d.pass;
  assign o_fv[3] = if_d.first_err_vld; assign o_cnt[3] = 32'(if_d.err_cnt); assign o_first[3] = 32'(if_d.first_err);

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (session timeline view) ----------------
  // A session accepted at edge t0 samples pattern p at edge t0+LAT+1+p.
  int  edge_n;
  bit  m_busy[N], m_done[N], m_fv[N];
  int  m_t0[N], m_err[N], m_first[N];
  logic [15:0] exp_q[$];   // expected {fv, first_err, err_cnt} per finished session of A
  bit  prev_done_a;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0; m_done[i] = 0; m_fv[i] = 0;
      m_t0[i] = 0; m_err[i] = 0; m_first[i] = 0;
    end
  endtask

  task automatic model_step(input bit st, input bit ab, input bit r);
    int k, p;
    edge_n++;
    for (int i = 0; i < N; i++) begin
      if (m_busy[i]) begin
        if (ab) begin
          m_busy[i] = 0;
        end else begin
          k = edge_n - m_t0[i];
          if (k > LATS[i]) begin
            p = k - LATS[i] - 1;
            if (r) begin
              if (m_err[i] < MAXS[i]) m_err[i]++;
              if (!m_fv[i]) begin m_fv[i] = 1; m_first[i] = p; end
            end
            if (p == PATS[i] - 1) begin
              m_busy[i] = 0;
              m_done[i] = 1;
              if (i == 0) exp_q.push_back({3'b0, m_fv[0], 4'(m_first[0]), 8'(m_err[0])});
            end
          end
        end
      end else if (st && !ab) begin
        m_busy[i] = 1; m_done[i] = 0; m_fv[i] = 0;
        m_t0[i] = edge_n; m_err[i] = 0; m_first[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [15:0] e;
    for (int i = 0; i < N; i++) begin
      check($sformatf("busy%0d", i),  32'(o_busy[i]), 32'(m_busy[i]));
      check($sformatf("done%0d", i),  32'(o_done[i]), 32'(m_done[i]));
      check($sformatf("pass%0d", i),  32'(o_pass[i]), 32'(m_done[i] && (m_err[i] == 0)));
      check($sformatf("cnt%0d", i),   o_cnt[i], 32'(m_err[i]));
      check($sformatf("first%0d", i), o_first[i], 32'(m_first[i]));
      check($sformatf("fv%0d", i),    32'(o_fv[i]), 32'(m_fv[i]));
    end
    if (o_done[0] === 1'b1 && !prev_done_a) begin
      check("sb_avail", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_result", {16'b0, 3'b0, o_fv[0], o_first[0][3:0], o_cnt[0][7:0]}, {16'b0, e});
      end
    end
    prev_done_a = (o_done[0] === 1'b1);
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit st, input bit ab, input bit r);
    start = st; abort = ab; res = r;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(st, ab, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle(0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  int busy_len;

  initial begin
    edge_n = 0;
    prev_done_a = 0;
    model_reset();
    #1 rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);

    // clean session on defaults
    busy_len = 0;
    cycle(1, 0, 0);
    if (o_busy[0]) busy_len++;
    for (int e = 1; e <= 17; e++) begin
      cycle(0, 0, 0);
      if (o_busy[0]) busy_len++;
    end
    check("t1_busy_len", 32'(busy_len), 32'd17);
    check("t1_done", 32'(o_done[0]), 32'd1);
    check("t1_pass", 32'(o_pass[0]), 32'd1);
    check("t1_cnt", o_cnt[0], 32'd0);
    check("t1_fv", 32'(o_fv[0]), 32'd0);
    idle(2);

    // mismatches on patterns 5 and 15 (edges E7, E17)
    cycle(1, 0, 0);
    for (int e = 1; e <= 17; e++) cycle(0, 0, (e == 7) || (e == 17));
    check("t2_done", 32'(o_done[0]), 32'd1);
    check("t2_cnt", o_cnt[0], 32'd2);
    check("t2_first", o_first[0], 32'd5);
    check("t2_fv", 32'(o_fv[0]), 32'd1);
    check("t2_pass", 32'(o_pass[0]), 32'd0);
    idle(2);

    // res high throughout: B saturates at 3
    cycle(1, 0, 1);
    for (int e = 1; e <= 17; e++) cycle(0, 0, 1);
    check("t3_cnt_b", o_cnt[1], 32'd3);
    check("t3_first_b", o_first[1], 32'd0);
    check("t3_pass_b", 32'(o_pass[1]), 32'd0);
    check("t3_cnt_a", o_cnt[0], 32'd16);
    idle(3);
    check("t3_hold_b", o_cnt[1], 32'd3);

    // abort on the pattern-9 sample edge, then a clean session
    cycle(1, 0, 0);
    for (int e = 1; e <= 10; e++) cycle(0, 0, 1'($urandom_range(0, 1)));
    cycle(0, 1, 1);
    check("t4_busy", 32'(o_busy[0]), 32'd0);
    check("t4_done", 32'(o_done[0]), 32'd0);
    idle(3);
    cycle(1, 0, 0);
    for (int e = 1; e <= 17; e++) cycle(0, 0, 0);
    check("t4_clean_pass", 32'(o_pass[0]), 32'd1);
    check("t4_clean_cnt", o_cnt[0], 32'd0);

    // start during COLLECT is ignored; start in DONE restarts
    cycle(1, 0, 0);
    for (int e = 1; e <= 16; e++) cycle(e == 8, 0, e == 12);
    check("t5_not_early", 32'(o_done[0]), 32'd0);
    cycle(0, 0, 0);
    check("t5_on_time", 32'(o_done[0]), 32'd1);
    check("t5_first", o_first[0], 32'd10);
    cycle(1, 0, 0);
    check("t5_restart_busy", 32'(o_busy[0]), 32'd1);
    check("t5_restart_cnt", o_cnt[0], 32'd0);
    for (int e = 1; e <= 17; e++) cycle(0, 0, 0);

    // PAT_COUNT=1, COMP_LAT=0: single sample at E1
    cycle(1, 0, 1);
    check("t6_busy_c", 32'(o_busy[2]), 32'd1);
    cycle(0, 0, 1);
    check("t6_done_c", 32'(o_done[2]), 32'd1);
    check("t6_cnt_c", o_cnt[2], 32'd1);
    check("t6_pass_c", 32'(o_pass[2]), 32'd0);
    for (int e = 2; e <= 17; e++) cycle(0, 0, 0);

    // randomized traffic
    for (int j = 0; j < 600; j++)
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0);
    idle(20);

    // asynchronous reset while D is in WAIT
    cycle(1, 0, 0);
    cycle(0, 0, 1);
    check("t7_d_busy_pre", 32'(o_busy[3]), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t7_state_d", 32'(if_d.dbg_state), 32'(IDLE));
    for (int i = 0; i < N; i++) begin
      check($sformatf("t7_async_busy%0d", i), 32'(o_busy[i]), 32'd0);
      check($sformatf("t7_async_cnt%0d", i), o_cnt[i], 32'd0);
      check($sformatf("t7_async_fv%0d", i), 32'(o_fv[i]), 32'd0);
    end
    model_reset();
    cycle(0, 0, 0);
    rst = 1'b0;
    idle(2);
    cycle(1, 0, 0);
    for (int e = 1; e <= 17; e++) cycle(0, 0, 0);
    check("t7_after_pass", 32'(o_pass[0]), 32'd1);
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ora_err_log.md
Name: ora_err_log

Overview:
- Response logger that sits directly downstream of the ORA #2 comparator. It consumes the comparator's per-pattern mismatch bit, `res` (1 = mismatch).
- Over one BIST session of PAT_COUNT patterns it:
  - compensates for the comparator's pipeline latency;
  - counts mismatches;
  - records the index of the first failing pattern;
  - reports a final pass/fail verdict to the BIST controller.

Parameters:
- PAT_COUNT, 16: number of patterns (comparator results) collected per session; must be ≥ 1.
- COMP_LAT, 1: clock edges between the session start edge and the first valid `res` sample, beyond the start edge itself; 0 is allowed.
- CNT_BITS, 8: width of the error counter; the counter saturates.
- IDX_BITS, $clog2(PAT_COUNT) (minimum 1): width of the pattern index. Derived; not to be overridden.

Ports:
- clk  in  1  system clock, rising edge active
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle session start request from the BIST controller
- abort  in  1  cancels the session in progress
- res  in  1  comparator result (0 = match, 1 = mismatch)
- busy  out  1  high while a session is collecting
- done  out  1  session complete; results valid
- pass  out  1  done and zero mismatches
- err_cnt  out  CNT_BITS  number of mismatching patterns (saturating)
- first_err  out  IDX_BITS  index of the first mismatching pattern
- first_err_vld  out  1  first_err holds a valid index

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: state = IDLE; busy = 0, done = 0, pass = 0, err_cnt = 0, first_err = 0, first_err_vld = 0; all internal counters = 0.
- FSM states: IDLE, WAIT, COLLECT, DONE. All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- IDLE or DONE, with start = 1 at an edge:
  - clear err_cnt, first_err, first_err_vld, pass and done;
  - go to WAIT if COMP_LAT > 0, otherwise to COLLECT;
  - load lat_cnt = 0 and pat_idx = 0.
- WAIT:
  - lat_cnt increments at each edge;
  - leaves for COLLECT on the edge where lat_cnt = COMP_LAT-1;
  - `res` is ignored in this state.
- COLLECT: at each edge, sample `res` for pattern pat_idx.
  - If res = 1: err_cnt += 1, holding at 2^CNT_BITS-1 once reached.
  - If res = 1 and first_err_vld = 0: first_err ← pat_idx and first_err_vld ← 1.
  - If pat_idx = PAT_COUNT-1: go to DONE. Otherwise pat_idx += 1.
- Sample timing: sampling edges are E(COMP_LAT+1) … E(COMP_LAT+PAT_COUNT), where E0 is the start edge.
- DONE:
  - done = 1 and pass = (err_cnt == 0);
  - results hold until the next accepted start or reset.
- busy = 1 exactly in WAIT and COLLECT.
- start while busy is ignored, with no effect on any counter.
- abort:
  - In WAIT or COLLECT, abort = 1 at an edge forces IDLE and sets busy = 0, done = 0, pass = 0. err_cnt, first_err and first_err_vld keep their partial values but are not valid because done = 0.
  - abort has priority over the sample taken on the same edge; that sample is discarded.
  - abort in IDLE or DONE has no effect.
- start and abort together in IDLE or DONE: abort wins and the state is unchanged.
- Reset mid-session: everything returns immediately to the reset values. No partial result is retained.
- An error on the last pattern is counted before DONE is entered, so done and its final err_cnt appear in the same cycle.
- first_err stays stable after the first mismatch and is never overwritten by later mismatches.

Decomposition:
- Shared LBIST package holds:
  - the FSM state encoding: IDLE=2'd0, WAIT=2'd1, COLLECT=2'd2, DONE=2'd3;
  - a function or constant for the saturating maximum of CNT_BITS.
- One natural sub-module: `sat_counter` (parameter WIDTH; ports clear, inc, count). It is reusable by the other ORA variants.
- Latency compensation and index counting stay inline.

Test Plan:
- Defaults, `res` held 0 for the whole session, start pulsed at E0 → busy for 17 cycles; done = 1 and pass = 1 after edge E17; err_cnt = 0, first_err_vld = 0.
- Defaults, `res` = 1 only on the pattern-5 sample edge (E7) and the pattern-15 sample edge (E17) → done; err_cnt = 2, first_err = 5, first_err_vld = 1, pass = 0.
- CNT_BITS = 2, `res` = 1 on all 16 samples → err_cnt saturates at 3 and holds; first_err = 0; pass = 0.
- abort at the pattern-9 sample edge with res = 1 → IDLE, busy = 0, done = 0; a later start fully clears state and a clean session passes.
- start re-pulsed during COLLECT → ignored; done still appears on the original schedule (E17). start in DONE → results clear and a new session runs.
- COMP_LAT = 0 and PAT_COUNT = 1 → the single sample is taken at E1 and done follows immediately after. Asserting `rst` mid-WAIT → all outputs are 0 asynchronously, before the next clock edge.
